// File: rtl/priority_enc_seq.sv
// priority_enc_seq: sequential leading/trailing-one detector.
// Scans a WIDTH-bit vector CHUNK bits per cycle and stops at the first nonzero
// slice. It reports the 1-based position of the highest set bit (MSB mode) or
// the lowest set bit (LSB mode). A result of 0 with out_zero=1 means no bit was
// set. Requests and results each use a valid/ready handshake.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request; in_ready=1
// SCAN  | examining one CHUNK slice per cycle from the chosen end
// DONE  | result presented on out_pos/out_zero until out_ready
module priority_enc_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int OW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lsb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OW-1:0]    out_pos,
  output logic             out_zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CIW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LW     = $clog2(CHUNK + 1);

  // WIDTH must split into whole slices.
  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("priority_enc_seq: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] data_q;
  logic             lsb_q;
  logic [CIW-1:0]   chunk_idx;

  logic             accept;
  logic [CHUNK-1:0] slice;
  logic             slice_nz;
  logic [LW-1:0]    local_pos;
  logic             last_chunk;
  logic [OW-1:0]    pos_hit;

  assign accept = in_valid && in_ready;

  // Select the slice addressed by chunk_idx.
  always_comb begin
    slice = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (chunk_idx == CIW'(c)) begin
        slice = data_q[c*CHUNK +: CHUNK];
      end
    end
  end

  // Local 1-based position inside the slice. The loop direction makes the
  // last matching bit win: ascending finds the highest, descending the lowest.
  always_comb begin
    local_pos = '0;
    if (lsb_q) begin
      for (int i = CHUNK - 1; i >= 0; i--) begin
        if (slice[i]) local_pos = LW'(i + 1);
      end
    end else begin
      for (int i = 0; i < CHUNK; i++) begin
        if (slice[i]) local_pos = LW'(i + 1);
      end
    end
  end

  // Slice status, the end-of-scan test and the absolute hit position.
  // The last-chunk test is evaluated before any index step, so the index
  // never wraps.
  always_comb begin
    slice_nz   = |slice;
    last_chunk = lsb_q ? (chunk_idx == CIW'(NCHUNK - 1)) : (chunk_idx == '0);
    pos_hit    = OW'(chunk_idx) * OW'(CHUNK) + OW'(local_pos);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = SCAN;
      end
      SCAN: begin
        if (slice_nz || last_chunk) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs, decoded from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Request capture and scan index. The operand and mode are sampled only on
  // the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      lsb_q     <= 1'b0;
      chunk_idx <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        data_q    <= in_data;
        lsb_q     <= in_lsb_first;
        chunk_idx <= in_lsb_first ? '0 : CIW'(NCHUNK - 1);
      end
    end else if (state == SCAN) begin
      if (!slice_nz && !last_chunk) begin
        chunk_idx <= lsb_q ? (chunk_idx + CIW'(1)) : (chunk_idx - CIW'(1));
      end
    end
  end

  // Result registers. They are written once at the end of a scan and hold
  // through DONE and the following IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pos  <= '0;
      out_zero <= 1'b0;
    end else if (state == SCAN) begin
      if (slice_nz) begin
        out_pos  <= pos_hit;
        out_zero <= 1'b0;
      end else if (last_chunk) begin
        out_pos  <= '0;
        out_zero <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_priority_enc_seq.sv
// Directed bench for priority_enc_seq: a 32/8 instance for the scan cases and
// an 8/8 instance for the exhaustive single-chunk sweep.
module tb_priority_enc_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [31:0] a_in_data = '0;
  logic        a_in_lsb_first = 1'b0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [5:0]  a_out_pos;
  logic        a_out_zero;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [7:0]  b_in_data = '0;
  logic        b_in_lsb_first = 1'b0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [3:0]  b_out_pos;
  logic        b_out_zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  priority_enc_seq #(.WIDTH(32), .CHUNK(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_lsb_first(a_in_lsb_first),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_pos(a_out_pos), .out_zero(a_out_zero)
  );

  priority_enc_seq #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_lsb_first(b_in_lsb_first),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pos(b_out_pos), .out_zero(b_out_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge while the 32-bit DUT is idle; returns #1 after the accept edge.
  task automatic a_request(input string tag, input logic [31:0] d, input logic lsb);
    chk({tag, "_in_ready"}, a_in_ready, 1);
    a_in_valid     = 1'b1;
    a_in_data      = d;
    a_in_lsb_first = lsb;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
  endtask

  task automatic a_wait_result(input string tag, input int exp_pos, input bit exp_zero, input int exp_n);
    int cnt = 0;
    while (cnt < 20) begin
      @(posedge clk);
      cnt++;
      #1;
      if (a_out_valid) break;
    end
    chk({tag, "_latency"}, cnt, exp_n);
    chk({tag, "_pos"}, a_out_pos, exp_pos);
    chk({tag, "_zero"}, a_out_zero, exp_zero);
  endtask

  task automatic a_release(input string tag);
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    chk({tag, "_valid_drop"}, a_out_valid, 0);
    chk({tag, "_idle_ready"}, a_in_ready, 1);
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #1;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_pos", a_out_pos, 0);
    chk("rst_a_zero", a_out_zero, 0);
    chk("rst_b_valid", b_out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_a_ready", a_in_ready, 1);
    chk("rst_b_ready", b_in_ready, 1);
    chk("rst_a_pos_after", a_out_pos, 0);

    // Basic scans.
    a_request("msb_80", 32'h0000_0080, 1'b0);
    a_wait_result("msb_80", 8, 0, 4);
    a_release("msb_80");

    a_request("msb_8001", 32'h8000_0001, 1'b0);
    a_wait_result("msb_8001", 32, 0, 1);
    a_release("msb_8001");

    a_request("lsb_8001", 32'h8000_0001, 1'b1);
    a_wait_result("lsb_8001", 1, 0, 1);
    a_release("lsb_8001");

    a_request("lsb_8000", 32'h8000_0000, 1'b1);
    a_wait_result("lsb_8000", 32, 0, 4);
    a_release("lsb_8000");

    a_request("msb_zero", 32'h0000_0000, 1'b0);
    a_wait_result("msb_zero", 0, 1, 4);
    a_release("msb_zero");

    a_request("lsb_zero", 32'h0000_0000, 1'b1);
    a_wait_result("lsb_zero", 0, 1, 4);
    a_release("lsb_zero");

    a_request("msb_1_0000", 32'h0001_0000, 1'b0);
    a_wait_result("msb_1_0000", 17, 0, 2);
    a_release("msb_1_0000");

    // Backpressure: lowest bit of 0xF000 is bit 12 -> position 13 after two slices.
    a_request("bp_first", 32'h0000_F000, 1'b1);
    a_wait_result("bp_first", 13, 0, 2);
    for (int k = 0; k < 10; k++) begin
      a_in_valid     = 1'b1;
      a_in_data      = (k == 9) ? 32'h0040_0000 : $urandom;
      a_in_lsb_first = (k == 9) ? 1'b0 : k[0];
      @(posedge clk);
      #1;
      chk("bp_hold_valid", a_out_valid, 1);
      chk("bp_hold_pos", a_out_pos, 13);
      chk("bp_hold_zero", a_out_zero, 0);
      chk("bp_hold_in_ready", a_in_ready, 0);
    end
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    chk("bp_release_valid", a_out_valid, 0);
    chk("bp_release_ready", a_in_ready, 1);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    a_wait_result("bp_second", 23, 0, 2);
    a_release("bp_second");

    // Reset during the second scan cycle.
    a_request("rst_scan", 32'h0000_0001, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_scan_valid", a_out_valid, 0);
    chk("rst_scan_pos", a_out_pos, 0);
    chk("rst_scan_zero", a_out_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_scan_ready", a_in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("rst_scan_no_stale", a_out_valid, 0);
    end
    a_request("after_rst", 32'h0000_0040, 1'b0);
    a_wait_result("after_rst", 7, 0, 4);
    a_release("after_rst");

    // 8-bit single-chunk sweep with random out_ready.
    for (int v = 0; v < 256; v++) begin
      int exp_pos;
      int cnt;
      logic [7:0] vv;
      vv = 8'(v);
      exp_pos = 0;
      for (int i = 0; i < 8; i++) if (vv[i]) exp_pos = i + 1;
      chk("sw_in_ready", b_in_ready, 1);
      b_in_valid     = 1'b1;
      b_in_data      = vv;
      b_in_lsb_first = 1'b0;
      b_out_ready    = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      b_in_valid  = 1'b0;
      b_out_ready = 1'($urandom_range(0, 1));
      cnt = 0;
      while (cnt < 10) begin
        @(posedge clk);
        cnt++;
        #1;
        if (b_out_valid) break;
        b_out_ready = 1'($urandom_range(0, 1));
      end
      chk("sw_latency", cnt, 1);
      chk("sw_pos", b_out_pos, exp_pos);
      chk("sw_zero", b_out_zero, (v == 0) ? 1 : 0);
      for (int w = 0; w < 40; w++) begin
        logic rdy;
        rdy = (w == 39) ? 1'b1 : 1'($urandom_range(0, 1));
        b_out_ready = rdy;
        @(posedge clk);
        #1;
        if (rdy) begin
          chk("sw_release", b_out_valid, 0);
          break;
        end
        chk("sw_hold_pos", b_out_pos, exp_pos);
      end
      b_out_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
